// File: rtl/mlp_pkg.sv
// Shared constants and FSM encoding for the 784-32-10 MLP weight sequencer.
// The parameter defaults of the sequencer and its address counters come from here.
package mlp_pkg;

    localparam int unsigned N_IN      = 784;
    localparam int unsigned N_HID     = 32;
    localparam int unsigned N_OUT     = 10;
    localparam int unsigned AW        = 32;
    localparam int unsigned HID_SEL_W = 5;

    typedef enum logic [2:0] {
        StIdle,
        StL1,
        StL1Drain,
        StL2,
        StL2Drain,
        StDone
    } seq_state_e;

    // True in the states where the CPU-facing handshake reports a pass in flight.
    function automatic logic state_is_busy(input seq_state_e s);
        return (s != StIdle) && (s != StDone);
    endfunction

endpackage

// File: rtl/layer_addr_ctr.sv
// Per-layer address counter: sweeps 0..LIMIT while running and emits strobes
// one cycle later, aligned to the weight memory's read latency.
module layer_addr_ctr #(
    parameter int unsigned AW    = mlp_pkg::AW,
    parameter int unsigned LIMIT = mlp_pkg::N_IN,
    parameter int unsigned IW    = mlp_pkg::HID_SEL_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run_i,
    input  logic          consume_i,
    output logic [AW-1:0] cnt_o,
    output logic          at_last_o,
    output logic          acc_en_o,
    output logic          bias_o,
    output logic [IW-1:0] idx_o
);
    import mlp_pkg::*;

    localparam logic [AW-1:0] LimitW = AW'(LIMIT);

    logic [AW-1:0] cnt_q, cnt_d;
    logic          acc_en_q;
    logic          bias_q;
    logic [IW-1:0] idx_q;

    assign at_last_o = (cnt_q == LimitW);

    // Saturate on the bias row; the FSM leaves the layer on that same consume.
    always_comb begin
        cnt_d = cnt_q;
        if (!run_i) begin
            cnt_d = '0;
        end else if (consume_i && !at_last_o) begin
            cnt_d = cnt_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            acc_en_q <= 1'b0;
            bias_q   <= 1'b0;
            idx_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            acc_en_q <= run_i && consume_i;
            bias_q   <= run_i && consume_i && at_last_o;
            if (consume_i) begin
                idx_q <= cnt_q[IW-1:0];
            end
        end
    end

    assign cnt_o    = cnt_q;
    assign acc_en_o = acc_en_q;
    assign bias_o   = bias_q;
    assign idx_o    = idx_q;

endmodule

// File: rtl/mlp_weight_sequencer.sv
// Sequences one inference pass of the MLP: layer-1 then layer-2 weight sweeps,
// with clear/accumulate/bias/last strobes and the start/busy/done handshake.
module mlp_weight_sequencer #(
    parameter int unsigned N_IN  = mlp_pkg::N_IN,
    parameter int unsigned N_HID = mlp_pkg::N_HID,
    parameter int unsigned AW    = mlp_pkg::AW
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start_i,
    input  logic                          stall_i,
    output logic [AW-1:0]                 ctr1_o,
    output logic [AW-1:0]                 ctr2_o,
    output logic                          l1_clr_o,
    output logic                          l1_acc_en_o,
    output logic                          l1_bias_o,
    output logic                          l1_last_o,
    output logic                          l2_clr_o,
    output logic                          l2_acc_en_o,
    output logic                          l2_bias_o,
    output logic                          l2_last_o,
    output logic [mlp_pkg::HID_SEL_W-1:0] l2_hid_sel_o,
    output logic                          busy_o,
    output logic                          done_o
);
    import mlp_pkg::*;

    seq_state_e state_q, state_d;
    logic       l1_clr_q, l2_clr_q, busy_q, done_q;

    logic l1_run, l1_consume, l1_at_last, l1_bias;
    logic l2_run, l2_consume, l2_at_last, l2_bias;
    logic l1_idx_unused;

    // Each counter keeps its final address through its drain cycle, zero otherwise.
    assign l1_run     = (state_q == StL1) || (state_q == StL1Drain);
    assign l2_run     = (state_q == StL2) || (state_q == StL2Drain);
    assign l1_consume = (state_q == StL1) && !stall_i;
    assign l2_consume = (state_q == StL2) && !stall_i;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start_i) state_d = StL1;
            StL1:      if (l1_consume && l1_at_last) state_d = StL1Drain;
            StL1Drain: state_d = StL2;
            StL2:      if (l2_consume && l2_at_last) state_d = StL2Drain;
            StL2Drain: state_d = StDone;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            l1_clr_q <= 1'b0;
            l2_clr_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            l1_clr_q <= (state_q == StIdle) && start_i;
            l2_clr_q <= (state_q == StL1Drain);
            done_q   <= (state_q == StL2Drain);
            busy_q   <= state_is_busy(state_d);
        end
    end

    layer_addr_ctr #(
        .AW   (AW),
        .LIMIT(N_IN),
        .IW   (1)
    ) u_l1_ctr (
        .clk      (clk),
        .reset    (reset),
        .run_i    (l1_run),
        .consume_i(l1_consume),
        .cnt_o    (ctr1_o),
        .at_last_o(l1_at_last),
        .acc_en_o (l1_acc_en_o),
        .bias_o   (l1_bias),
        .idx_o    (l1_idx_unused)
    );

    layer_addr_ctr #(
        .AW   (AW),
        .LIMIT(N_HID),
        .IW   (HID_SEL_W)
    ) u_l2_ctr (
        .clk      (clk),
        .reset    (reset),
        .run_i    (l2_run),
        .consume_i(l2_consume),
        .cnt_o    (ctr2_o),
        .at_last_o(l2_at_last),
        .acc_en_o (l2_acc_en_o),
        .bias_o   (l2_bias),
        .idx_o    (l2_hid_sel_o)
    );

    assign l1_bias_o = l1_bias;
    assign l1_last_o = l1_bias;
    assign l2_bias_o = l2_bias;
    assign l2_last_o = l2_bias;
    assign l1_clr_o  = l1_clr_q;
    assign l2_clr_o  = l2_clr_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_mlp_weight_sequencer.sv
// Bench for mlp_weight_sequencer: table-driven stall scenarios, hand-written
// start-hold and mid-pass reset sequences, and random stall passes vs a schedule model.
module tb_mlp_weight_sequencer;
    import mlp_pkg::*;

    localparam int NI   = 784;
    localparam int NH   = 32;
    localparam int MAXC = 3000;

    logic        clk = 1'b0;
    logic        reset, start_i, stall_i;
    logic [31:0] ctr1_o, ctr2_o;
    logic        l1_clr_o, l1_acc_en_o, l1_bias_o, l1_last_o;
    logic        l2_clr_o, l2_acc_en_o, l2_bias_o, l2_last_o;
    logic [4:0]  l2_hid_sel_o;
    logic        busy_o, done_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mlp_weight_sequencer #(
        .N_IN (NI),
        .N_HID(NH),
        .AW   (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start_i),
        .stall_i     (stall_i),
        .ctr1_o      (ctr1_o),
        .ctr2_o      (ctr2_o),
        .l1_clr_o    (l1_clr_o),
        .l1_acc_en_o (l1_acc_en_o),
        .l1_bias_o   (l1_bias_o),
        .l1_last_o   (l1_last_o),
        .l2_clr_o    (l2_clr_o),
        .l2_acc_en_o (l2_acc_en_o),
        .l2_bias_o   (l2_bias_o),
        .l2_last_o   (l2_last_o),
        .l2_hid_sel_o(l2_hid_sel_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    // Address-encoded weight memories with one-cycle read latency.
    logic [15:0] w1_mem [0:NI];
    logic [15:0] w2_mem [0:NH];
    logic [15:0] w1_q, w2_q;

    always @(posedge clk) begin
        w1_q <= (ctr1_o <= 32'(NI)) ? w1_mem[ctr1_o] : 16'hxxxx;
        w2_q <= (ctr2_o <= 32'(NH)) ? w2_mem[ctr2_o] : 16'hxxxx;
    end

    // Expected per-cycle schedule, indexed by cycle offset from start acceptance.
    bit pat     [MAXC];
    int e_ctr1  [MAXC];
    int e_ctr2  [MAXC];
    int e_a1    [MAXC];
    int e_a2    [MAXC];
    bit e_acc1  [MAXC];
    bit e_bias1 [MAXC];
    bit e_clr1  [MAXC];
    bit e_acc2  [MAXC];
    bit e_bias2 [MAXC];
    bit e_clr2  [MAXC];
    bit e_busy  [MAXC];
    bit e_done  [MAXC];
    int m_done;

    typedef struct {
        string name;
        int    layer;
        int    addr;
        int    len;
        int    done_off;
    } vec_t;
    vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0d: got %0h, want %0h", name, k, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ctr1"}, -1, ctr1_o, 32'd0);
        check({tag, "_ctr2"}, -1, ctr2_o, 32'd0);
        check({tag, "_strobes"}, -1,
              32'({l1_clr_o, l1_acc_en_o, l1_bias_o, l1_last_o, l2_clr_o, l2_acc_en_o,
                   l2_bias_o, l2_last_o, busy_o, done_o}), 32'd0);
        check({tag, "_hid_sel"}, -1, 32'(l2_hid_sel_o), 32'd0);
    endtask

    // Walk the issue rule over the stall pattern: an address is consumed in any
    // layer cycle without stall, and its strobes appear one cycle later.
    task automatic build_model();
        int c, a, b;
        for (int k = 0; k < MAXC; k++) begin
            e_ctr1[k] = -1;  e_ctr2[k] = -1;  e_a1[k] = 0;  e_a2[k] = 0;
            e_acc1[k] = 0;   e_bias1[k] = 0;  e_clr1[k] = 0;
            e_acc2[k] = 0;   e_bias2[k] = 0;  e_clr2[k] = 0;
            e_busy[k] = 0;   e_done[k] = 0;
        end
        e_ctr1[0] = 0;
        e_ctr2[0] = 0;
        c = 1;
        a = 0;
        e_clr1[1] = 1;
        while (a <= NI && c < MAXC - 8) begin
            e_ctr1[c] = a;
            if (!pat[c]) begin
                e_acc1[c + 1]  = 1;
                e_a1[c + 1]    = a;
                e_bias1[c + 1] = (a == NI);
                a++;
            end
            c++;
        end
        e_ctr1[c] = NI;
        e_ctr2[c] = 0;
        c++;
        b = 0;
        e_clr2[c] = 1;
        while (b <= NH && c < MAXC - 8) begin
            e_ctr2[c] = b;
            if (!pat[c]) begin
                e_acc2[c + 1]  = 1;
                e_a2[c + 1]    = b;
                e_bias2[c + 1] = (b == NH);
                b++;
            end
            c++;
        end
        m_done = c + 1;
        e_done[m_done] = 1;
        for (int k = 1; k < m_done; k++) e_busy[k] = 1;
    endtask

    task automatic compare_cycle(input string tag, input int k);
        if (e_ctr1[k] >= 0) check({tag, "_ctr1"}, k, ctr1_o, 32'(e_ctr1[k]));
        if (e_ctr2[k] >= 0) check({tag, "_ctr2"}, k, ctr2_o, 32'(e_ctr2[k]));
        check({tag, "_l1_clr"}, k, 32'(l1_clr_o), 32'(e_clr1[k]));
        check({tag, "_l1_acc"}, k, 32'(l1_acc_en_o), 32'(e_acc1[k]));
        check({tag, "_l1_bias"}, k, 32'(l1_bias_o), 32'(e_bias1[k]));
        check({tag, "_l1_last"}, k, 32'(l1_last_o), 32'(e_bias1[k]));
        check({tag, "_l2_clr"}, k, 32'(l2_clr_o), 32'(e_clr2[k]));
        check({tag, "_l2_acc"}, k, 32'(l2_acc_en_o), 32'(e_acc2[k]));
        check({tag, "_l2_bias"}, k, 32'(l2_bias_o), 32'(e_bias2[k]));
        check({tag, "_l2_last"}, k, 32'(l2_last_o), 32'(e_bias2[k]));
        check({tag, "_done"}, k, 32'(done_o), 32'(e_done[k]));
        if (k != m_done) check({tag, "_busy"}, k, 32'(busy_o), 32'(e_busy[k]));
        if (e_acc1[k]) check({tag, "_w1_data"}, k, 32'(w1_q), 32'(w1_mem[e_a1[k]]));
        if (e_acc2[k]) begin
            check({tag, "_w2_data"}, k, 32'(w2_q), 32'(w2_mem[e_a2[k]]));
            check({tag, "_hid_sel"}, k, 32'(l2_hid_sel_o), 32'(e_a2[k] % 32));
        end
    endtask

    task automatic run_pass(input string tag, input int exp_done, input bit hold,
                            input int abort_at);
        int n1, n2, seen;
        n1   = 0;
        n2   = 0;
        seen = -1;
        check({tag, "_start_ctr1"}, 0, ctr1_o, 32'd0);
        check({tag, "_start_ctr2"}, 0, ctr2_o, 32'd0);
        check({tag, "_start_busy"}, 0, 32'(busy_o), 32'd0);
        start_i = 1'b1;
        stall_i = pat[0];
        tick();
        for (int k = 1; k <= exp_done + 1; k++) begin
            start_i = hold;
            compare_cycle(tag, k);
            if (l1_acc_en_o) n1++;
            if (l2_acc_en_o) n2++;
            if (done_o && seen < 0) seen = k;
            stall_i = pat[k];
            if (k == abort_at) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                check_idle({tag, "_post_reset"});
                for (int j = 0; j < 40; j++) begin
                    start_i = 1'b0;
                    stall_i = j[0];
                    tick();
                    check({tag, "_after_reset_quiet"}, j, 32'({busy_o, done_o}), 32'd0);
                end
                return;
            end
            tick();
        end
        check({tag, "_done_cycle"}, 0, 32'(seen), 32'(exp_done));
        check({tag, "_l1_acc_count"}, 0, 32'(n1), 32'(NI + 1));
        check({tag, "_l2_acc_count"}, 0, 32'(n2), 32'(NH + 1));
        start_i = 1'b0;
        stall_i = 1'b0;
    endtask

    initial begin
        int base;
        for (int a = 0; a <= NI; a++) w1_mem[a] = 16'(a * 40503 + 17);
        for (int b = 0; b <= NH; b++) w2_mem[b] = 16'(b * 97 + 5);

        vecs[0] = '{"no_stall",         1, 0,   0, 821};
        vecs[1] = '{"l1_stall_100x3",   1, 100, 3, 824};
        vecs[2] = '{"l1_stall_0x1",     1, 0,   1, 822};
        vecs[3] = '{"l1_stall_bias_x4", 1, 784, 4, 825};
        vecs[4] = '{"l2_stall_5x2",     2, 5,   2, 823};
        vecs[5] = '{"l2_stall_bias_x3", 2, 32,  3, 824};
        vecs[6] = '{"idle_stall",       0, 0,   1, 821};
        vecs[7] = '{"drain_stall",      0, 786, 1, 821};

        reset   = 1'b1;
        start_i = 1'b0;
        stall_i = 1'b0;
        repeat (3) tick();
        check_idle("reset");
        start_i = 1'b1;
        stall_i = 1'b1;
        tick();
        check_idle("reset_ignores_start");
        reset   = 1'b0;
        start_i = 1'b0;
        stall_i = 1'b0;
        tick();
        check_idle("after_reset");

        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < MAXC; k++) pat[k] = 1'b0;
            base = (vecs[i].layer == 1) ? 1 + vecs[i].addr :
                   (vecs[i].layer == 2) ? 787 + vecs[i].addr : vecs[i].addr;
            for (int j = 0; j < vecs[i].len; j++) pat[base + j] = 1'b1;
            build_model();
            run_pass(vecs[i].name, vecs[i].done_off, 1'b0, -1);
            tick();
        end

        // start held high: one pass, then a new one right after DONE returns to IDLE.
        for (int k = 0; k < MAXC; k++) pat[k] = 1'b0;
        build_model();
        run_pass("hold_start", 821, 1'b1, -1);
        check("hold_restart_clr", 823, 32'(l1_clr_o), 32'd1);
        check("hold_restart_busy", 823, 32'(busy_o), 32'd1);
        check("hold_restart_ctr1", 823, ctr1_o, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("hold_abort");

        // Reset mid-L2 at ctr2 = 5, then a full clean pass.
        run_pass("abort_l2", 821, 1'b0, 792);
        run_pass("after_abort", 821, 1'b0, -1);
        tick();

        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(5)) begin
                stall_i = 1'($urandom);
                tick();
                check("gap_idle", r, 32'({busy_o, done_o}), 32'd0);
            end
            for (int k = 0; k < MAXC; k++) pat[k] = ($urandom_range(3) == 0);
            build_model();
            run_pass("random", m_done, 1'b0, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
